led_pattern_player: RTL and testbench



---
 rtl/ledplay_pkg.sv | 28 ++
 rtl/pattern_rom.sv | 35 +++
 rtl/led_pattern_player.sv | 140 ++++++++++++++
 tb/tb_led_pattern_player.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledplay_pkg.sv
// Shared definitions for the LED pattern player: playback modes, FSM states
// and the default pattern table.
package ledplay_pkg;

  localparam int unsigned PAT_W = 4;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_LOOP     = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SHOW = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Default contents for addresses 0..7; every other address reads as zero.
  localparam logic [PAT_W-1:0] PAT_0 = 4'b0001;
  localparam logic [PAT_W-1:0] PAT_1 = 4'b0010;
  localparam logic [PAT_W-1:0] PAT_2 = 4'b0100;
  localparam logic [PAT_W-1:0] PAT_3 = 4'b1000;
  localparam logic [PAT_W-1:0] PAT_4 = 4'b0100;
  localparam logic [PAT_W-1:0] PAT_5 = 4'b0010;
  localparam logic [PAT_W-1:0] PAT_6 = 4'b0001;
  localparam logic [PAT_W-1:0] PAT_7 = 4'b0001;

endpackage

// File: rtl/pattern_rom.sv
// Synchronous-read pattern ROM: data for the address presented at one edge
// appears after that edge.
module pattern_rom
  import ledplay_pkg::*;
#(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] word;

  always_comb begin
    word = '0;
    case (32'(address))
      0:       word = DATA_W'(PAT_0);
      1:       word = DATA_W'(PAT_1);
      2:       word = DATA_W'(PAT_2);
      3:       word = DATA_W'(PAT_3);
      4:       word = DATA_W'(PAT_4);
      5:       word = DATA_W'(PAT_5);
      6:       word = DATA_W'(PAT_6);
      7:       word = DATA_W'(PAT_7);
      default: word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    data <= word;
  end

endmodule

// File: rtl/led_pattern_player.sv
// LED pattern sequencer: steps a pattern ROM in one-shot, loop or ping-pong
// order. Optional pause input enabled by LEDPLAY_PAUSE_EN.
module led_pattern_player
  import ledplay_pkg::*;
#(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] last_addr,
`ifdef LEDPLAY_PAUSE_EN
  input  logic              pause,
`endif
  output logic [DATA_W-1:0] leds,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [1:0]        mode_q, mode_d;
  logic              dir_up, dir_up_d;
  logic [CNT_W-1:0]  hold_cnt;
  logic              hold_freeze;
  logic              hold_end;
  logic              at_last, at_zero;
  logic [DATA_W-1:0] rom_data;

`ifdef LEDPLAY_PAUSE_EN
  assign hold_freeze = (state == ST_SHOW) && pause;
`else
  assign hold_freeze = 1'b0;
`endif

  assign hold_end = (state == ST_SHOW) && !hold_freeze && (hold_cnt == HOLD_LAST);
  assign at_last  = (address == last_q);
  assign at_zero  = (address == '0);

  // The ROM is fed the next address so its data is ready by the end of LOAD.
  pattern_rom #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clock   (clock),
    .address (addr_d),
    .data    (rom_data)
  );

  always_comb begin
    state_d  = state;
    addr_d   = address;
    dir_up_d = dir_up;
    mode_d   = mode_q;
    last_d   = last_q;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_LOAD;
          addr_d   = '0;
          dir_up_d = 1'b1;
          mode_d   = mode;
          last_d   = last_addr;
        end
      end
      ST_LOAD: state_d = ST_SHOW;
      ST_SHOW: begin
        if (hold_end) begin
          state_d = ST_LOAD;
          case (mode_q)
            MODE_LOOP: addr_d = at_last ? '0 : address + ADDR_W'(1);
            MODE_PINGPONG: begin
              // A zero-length ping-pong run simply repeats address 0.
              if (dir_up) begin
                if (!at_last) begin
                  addr_d = address + ADDR_W'(1);
                end else if (!at_zero) begin
                  dir_up_d = 1'b0;
                  addr_d   = address - ADDR_W'(1);
                end
              end else if (at_zero) begin
                dir_up_d = 1'b1;
                addr_d   = address + ADDR_W'(1);
              end else begin
                addr_d = address - ADDR_W'(1);
              end
            end
            default: begin
              if (at_last) state_d = ST_DONE;
              else         addr_d  = address + ADDR_W'(1);
            end
          endcase
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (stop) begin
      state_d  = ST_IDLE;
      addr_d   = '0;
      dir_up_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      leds     <= '0;
      address  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hold_cnt <= '0;
      dir_up   <= 1'b1;
      mode_q   <= MODE_ONESHOT;
      last_q   <= '0;
    end else begin
      state   <= state_d;
      address <= addr_d;
      dir_up  <= dir_up_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      busy    <= (state_d == ST_LOAD) || (state_d == ST_SHOW);
      done    <= (state_d == ST_DONE);
      if (stop)                  leds <= '0;
      else if (state == ST_LOAD) leds <= rom_data;
      if (stop || state != ST_SHOW || hold_end) hold_cnt <= '0;
      else if (!hold_freeze)                    hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_led_pattern_player.sv
// Self-checking bench for led_pattern_player: table of playback runs checked
// cycle by cycle against a step-schedule model, plus hand-written corners.
module tb_led_pattern_player;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned HOLD   = 4;

  typedef struct packed {
    logic [DATA_W-1:0] leds;
    logic [ADDR_W-1:0] address;
    logic              busy;
    logic              done;
  } obs_t;

  typedef struct {
    logic [1:0] mode;
    logic [3:0] last;
    int         cycles;
    int         mid_start;
    int         abort_at;
    bit         abort_rst;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [1:0]        mode = 2'b00;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [DATA_W-1:0] leds;
  logic [ADDR_W-1:0] address;
  logic              busy;
  logic              done;
`ifdef LEDPLAY_PAUSE_EN
  logic              pause = 1'b0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];
  vec_t vecs[11];

  always #5 clock = ~clock;

  led_pattern_player #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .last_addr (last_addr),
`ifdef LEDPLAY_PAUSE_EN
    .pause     (pause),
`endif
    .leds      (leds),
    .address   (address),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [3:0] pat(input int a);
    case (a)
      0: return 4'b0001;
      1: return 4'b0010;
      2: return 4'b0100;
      3: return 4'b1000;
      4: return 4'b0100;
      5: return 4'b0010;
      6: return 4'b0001;
      7: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Address shown in step s of a run.
  function automatic int step_addr(input vec_t v, input int s);
    int l;
    int r;
    l = int'(v.last);
    if (v.mode == 2'b01) return s % (l + 1);
    if (v.mode == 2'b10) begin
      if (l == 0) return 0;
      r = s % (2 * l);
      return (r <= l) ? r : 2 * l - r;
    end
    return s;
  endfunction

  // Expected outputs just after edge n, where edge 1 samples the start pulse.
  function automatic obs_t model(input vec_t v, input int n);
    obs_t o;
    int   c;
    int   s;
    int   ph;
    int   l;
    o = '0;
    if (v.abort_at != 0 && n > v.abort_at) return o;
    l  = int'(v.last);
    c  = n - 1;
    s  = c / (HOLD + 1);
    ph = c % (HOLD + 1);
    if (v.mode != 2'b01 && v.mode != 2'b10 && s > l) begin
      o.leds    = pat(l);
      o.address = ADDR_W'(l);
      o.done    = (s == l + 1) && (ph == 0);
      return o;
    end
    o.address = ADDR_W'(step_addr(v, s));
    o.busy    = 1'b1;
    if (ph == 0) o.leds = (s == 0) ? 4'b0000 : pat(step_addr(v, s - 1));
    else         o.leds = pat(step_addr(v, s));
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got leds=%b addr=%0d busy=%b done=%b, required leds=%b addr=%0d busy=%b done=%b",
               name, got.leds, got.address, got.busy, got.done,
               req.leds, req.address, req.busy, req.done);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.leds    = leds;
    o.address = address;
    o.busy    = busy;
    o.done    = done;
    return o;
  endfunction

  task automatic pop_check(input string name);
    obs_t req;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      req = exp_q.pop_front();
      check(name, sample(), req);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    mode      = v.mode;
    last_addr = v.last;
    start     = 1'b1;
    for (int n = 1; n <= v.cycles; n++) begin
      @(posedge clock);
      #1;
      start = (v.mid_start != 0) && (n == v.mid_start);
      // Scramble mode/last_addr after start; the latched copies must be used.
      mode      = 2'($urandom);
      last_addr = ADDR_W'($urandom);
      reset_n   = 1'b1;
      stop      = 1'b0;
      if (v.abort_at != 0 && n == v.abort_at) begin
        if (v.abort_rst) reset_n = 1'b0;
        else             stop    = 1'b1;
      end
      exp_q.push_back(model(v, n));
      @(negedge clock);
      pop_check($sformatf("vec%0d_cyc%0d", idx, n));
    end
    start   = 1'b0;
    reset_n = 1'b1;
    stop    = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    exp_q.push_back('0);
    @(negedge clock);
    pop_check($sformatf("vec%0d_stop", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 4'd7, 46, 0, 0, 1'b0};
    vecs[1]  = '{2'b01, 4'd3, 34, 0, 30, 1'b0};
    vecs[2]  = '{2'b10, 4'd3, 50, 0, 0, 1'b0};
    vecs[3]  = '{2'b00, 4'd0, 10, 6, 0, 1'b0};
    vecs[4]  = '{2'b00, 4'd7, 46, 12, 0, 1'b0};
    vecs[5]  = '{2'b00, 4'd7, 24, 0, 17, 1'b1};
    vecs[6]  = '{2'b11, 4'd2, 20, 0, 0, 1'b0};
    vecs[7]  = '{2'b10, 4'd0, 15, 0, 0, 1'b0};
    vecs[8]  = '{2'b01, 4'd0, 14, 0, 0, 1'b0};
    vecs[9]  = '{2'b00, 4'd9, 55, 0, 0, 1'b0};
    vecs[10] = '{2'b10, 4'd5, 40, 0, 25, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    exp_q.push_back('0);
    pop_check("reset_state");
    reset_n = 1'b1;

    // start and stop together in IDLE must leave the player idle
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('0);
      @(negedge clock);
      pop_check($sformatf("start_stop_idle_%0d", k));
      @(posedge clock);
    end
    @(negedge clock);

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

`ifdef LEDPLAY_PAUSE_EN
    begin
      int   first_done;
      obs_t req;
      first_done = 0;
      mode       = 2'b00;
      last_addr  = 4'd7;
      start      = 1'b1;
      for (int n = 1; n <= 70; n++) begin
        @(posedge clock);
        #1;
        start = 1'b0;
        pause = (n >= 12) && (n <= 21);
        @(negedge clock);
        if (n >= 13 && n <= 22) begin
          req = '0;
          req.leds    = 4'b0100;
          req.address = 4'd2;
          req.busy    = 1'b1;
          check($sformatf("pause_hold_cyc%0d", n), sample(), req);
        end
        if (done && first_done == 0) first_done = n;
      end
      n_cmp++;
      if (first_done != 51) begin
        n_bad++;
        $display("FAIL pause_done_cycle: got %0d, required 51", first_done);
      end
      req      = '0;
      req.leds = 4'b0001;
      req.address = 4'd7;
      check("pause_after_done", sample(), req);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
